// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 key-event sequencer.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT  = 8'hE0;
    localparam logic [7:0] PS2_BRK  = 8'hF0;
    localparam logic [7:0] PS2_ERR0 = 8'h00;
    localparam logic [7:0] PS2_ERRF = 8'hFF;

    localparam int EV_W = 10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_E0   = 2'd1,
        S_F0   = 2'd2,
        S_E0F0 = 2'd3
    } state_e;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ev_t;

endpackage

// File: rtl/ps2_event_fifo.sv
// Synchronous first-word-fall-through FIFO for key events.
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int WIDTH = EV_W,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == (AW+1)'(DEPTH));
    assign dout  = mem_q[rd_ptr_q];

    // A pop frees the slot in the same cycle, so a full FIFO may still push.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/ps2_event_ctrl.sv
// PS/2 byte stream to key-event sequencer: prefix FSM, timeout,
// error/overflow accounting and an event FIFO.
module ps2_event_ctrl
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 50000,
    parameter int TMO_W       = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    input  logic       byte_err,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_break,
    output logic       overflow,
    output logic [7:0] err_cnt,
    input  logic       clr_sticky,
    output logic       busy
);

    state_e      state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic        ovf_q, ovf_d;

    logic        err;
    logic        emit;
    ev_t         emit_ev;
    logic        tmo_hit;
    logic        fifo_full, fifo_empty, pop;
    logic [EV_W-1:0] fifo_dout;
    ev_t         head;

    assign tmo_hit = (state_q != S_IDLE) && !byte_valid
                   && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d = state_q;
        err     = 1'b0;
        emit    = 1'b0;
        emit_ev = '{ext: 1'b0, brk: 1'b0, code: byte_data};
        if (byte_valid && byte_err) begin
            err     = 1'b1;
            state_d = S_IDLE;
        end else if (byte_valid) begin
            unique case (state_q)
                S_IDLE: begin
                    if (byte_data == PS2_EXT) begin
                        state_d = S_E0;
                    end else if (byte_data == PS2_BRK) begin
                        state_d = S_F0;
                    end else if (byte_data == PS2_ERR0 || byte_data == PS2_ERRF) begin
                        err = 1'b1;
                    end else begin
                        emit = 1'b1;
                    end
                end
                S_E0: begin
                    if (byte_data == PS2_BRK) begin
                        state_d = S_E0F0;
                    end else if (byte_data != PS2_EXT) begin
                        emit        = 1'b1;
                        emit_ev.ext = 1'b1;
                        state_d     = S_IDLE;
                    end
                end
                S_F0: begin
                    if (byte_data == PS2_EXT) begin
                        err     = 1'b1;
                        state_d = S_E0;
                    end else if (byte_data != PS2_BRK) begin
                        emit        = 1'b1;
                        emit_ev.brk = 1'b1;
                        state_d     = S_IDLE;
                    end
                end
                S_E0F0: begin
                    if (byte_data == PS2_EXT || byte_data == PS2_BRK) begin
                        err = 1'b1;
                    end else begin
                        emit        = 1'b1;
                        emit_ev.ext = 1'b1;
                        emit_ev.brk = 1'b1;
                    end
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end else if (tmo_hit) begin
            err     = 1'b1;
            state_d = S_IDLE;
        end
    end

    always_comb begin
        tmo_d = tmo_q + 1'b1;
        if (byte_valid || state_q == S_IDLE || tmo_hit) begin
            tmo_d = '0;
        end
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        ovf_d     = ovf_q;
        if (clr_sticky) begin
            err_cnt_d = '0;
            ovf_d     = 1'b0;
        end else begin
            if (err && err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
            if (emit && fifo_full && !pop) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            tmo_q     <= '0;
            err_cnt_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            err_cnt_q <= err_cnt_d;
            ovf_q     <= ovf_d;
        end
    end

    assign pop = ev_valid & ev_ready;

    ps2_event_fifo #(
        .WIDTH (EV_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (emit),
        .pop   (pop),
        .din   (emit_ev),
        .full  (fifo_full),
        .empty (fifo_empty),
        .dout  (fifo_dout)
    );

    // Storage is not reset, so the head is masked while nothing is held.
    assign head     = ev_t'(fifo_dout);
    assign ev_valid = ~fifo_empty;
    assign ev_code  = ev_valid ? head.code : 8'h00;
    assign ev_ext   = ev_valid & head.ext;
    assign ev_break = ev_valid & head.brk;
    assign overflow = ovf_q;
    assign err_cnt  = err_cnt_q;
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_ps2_event_ctrl.sv
// Scoreboard bench for ps2_event_ctrl with a flag-based reference model.
module tb_ps2_event_ctrl;

    localparam int DEPTH = 4;
    localparam int TMO   = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_data = 8'h00;
    logic       byte_err = 1'b0;
    logic       ev_valid;
    logic       ev_ready = 1'b0;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_break;
    logic       overflow;
    logic [7:0] err_cnt;
    logic       clr_sticky = 1'b0;
    logic       busy;

    ps2_event_ctrl #(
        .FIFO_DEPTH  (DEPTH),
        .TIMEOUT_CYC (TMO),
        .TMO_W       (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_err   (byte_err),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_code    (ev_code),
        .ev_ext     (ev_ext),
        .ev_break   (ev_break),
        .overflow   (overflow),
        .err_cnt    (err_cnt),
        .clr_sticky (clr_sticky),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state: pending prefixes as two flags.
    bit         m_ext, m_brk, m_ovf;
    int         m_err, m_gap;
    logic [9:0] m_fifo[$];
    logic [9:0] exp_q[$];

    task automatic chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && ev_valid && ev_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_event", {ev_ext, ev_break, ev_code}, 0);
            end else begin
                chk("event", {ev_ext, ev_break, ev_code}, exp_q.pop_front());
            end
        end
    end

    task automatic model_clear();
        m_ext = 0; m_brk = 0; m_ovf = 0;
        m_err = 0; m_gap = 0;
        m_fifo.delete();
        exp_q.delete();
    endtask

    task automatic model_cycle(bit bv, logic [7:0] d, bit be, bit rdy, bit clr);
        bit e = 0;
        bit em = 0;
        logic [9:0] ev = '0;
        bit pop = rdy && (m_fifo.size() != 0);
        if (bv) begin
            m_gap = 0;
            if (be) begin
                e = 1; m_ext = 0; m_brk = 0;
            end else if (d == 8'hE0) begin
                if (m_brk) e = 1;
                if (m_brk && m_ext) begin
                    m_ext = 0; m_brk = 0;
                end else begin
                    m_ext = 1; m_brk = 0;
                end
            end else if (d == 8'hF0) begin
                if (m_ext && m_brk) begin
                    e = 1; m_ext = 0; m_brk = 0;
                end else begin
                    m_brk = 1;
                end
            end else if (!m_ext && !m_brk && (d == 8'h00 || d == 8'hFF)) begin
                e = 1;
            end else begin
                em = 1; ev = {m_ext, m_brk, d};
                m_ext = 0; m_brk = 0;
            end
        end else if (m_ext || m_brk) begin
            m_gap++;
            if (m_gap == TMO) begin
                e = 1; m_ext = 0; m_brk = 0;
            end
        end
        if (pop) void'(m_fifo.pop_front());
        if (em) begin
            if (m_fifo.size() < DEPTH) begin
                m_fifo.push_back(ev);
                exp_q.push_back(ev);
            end else if (!clr) begin
                m_ovf = 1;
            end
        end
        if (clr) begin
            m_err = 0; m_ovf = 0;
        end else if (e && m_err < 255) begin
            m_err++;
        end
    endtask

    task automatic status(string tag);
        chk({tag, "_valid"}, ev_valid, m_fifo.size() != 0);
        chk({tag, "_errcnt"}, err_cnt, m_err);
        chk({tag, "_busy"}, busy, m_ext || m_brk);
        chk({tag, "_ovf"}, overflow, m_ovf);
    endtask

    task automatic step(bit bv, logic [7:0] d, bit be, bit rdy, bit clr);
        byte_valid = bv; byte_data = d; byte_err = be;
        ev_ready = rdy; clr_sticky = clr;
        model_cycle(bv, d, be, rdy, clr);
        @(posedge clk); #1;
        byte_valid = 0; byte_err = 0; clr_sticky = 0;
    endtask

    task automatic do_reset();
        rst = 1; ev_ready = 0; byte_valid = 0;
        model_clear();
        @(posedge clk); #1;
        rst = 0;
        chk("rst_valid", ev_valid, 0);
        chk("rst_code", ev_code, 0);
        chk("rst_ext_brk", {ev_ext, ev_break}, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_busy", busy, 0);
    endtask

    task automatic idle(int n, bit rdy);
        for (int i = 0; i < n; i++) begin
            step(0, 8'h00, 0, rdy, 0);
            status("idle");
        end
    endtask

    initial begin
        @(posedge clk); #1;
        do_reset();

        step(1, 8'h1C, 0, 0, 0);
        chk("latency", ev_valid, 1);
        status("t1");
        idle(2, 1);

        step(1, 8'hE0, 0, 1, 0);
        step(1, 8'hF0, 0, 1, 0);
        step(1, 8'h75, 0, 1, 0);
        status("t2a");
        step(1, 8'hE0, 0, 1, 0);
        step(1, 8'h75, 0, 1, 0);
        step(1, 8'hF0, 0, 1, 0);
        step(1, 8'h1C, 0, 1, 0);
        status("t2b");
        idle(2, 1);

        step(1, 8'hF0, 0, 1, 0);
        idle(TMO + 1, 1);
        chk("tmo_err", err_cnt, 1);
        chk("tmo_busy", busy, 0);
        step(1, 8'h1C, 0, 1, 0);
        idle(2, 1);

        do_reset();
        step(1, 8'hE0, 0, 1, 0);
        step(1, 8'h75, 1, 1, 0);
        chk("rxerr_cnt", err_cnt, 1);
        chk("rxerr_busy", busy, 0);
        step(1, 8'hF0, 0, 1, 0);
        step(1, 8'hE0, 0, 1, 0);
        chk("f0e0_cnt", err_cnt, 2);
        chk("f0e0_busy", busy, 1);
        step(1, 8'h11, 0, 1, 0);
        idle(2, 1);

        do_reset();
        step(1, 8'h1C, 0, 0, 0);
        step(1, 8'h1B, 0, 0, 0);
        step(1, 8'h23, 0, 0, 0);
        step(1, 8'h2B, 0, 0, 0);
        step(1, 8'h34, 0, 0, 0);
        chk("ovf_set", overflow, 1);
        status("t5a");
        step(0, 8'h00, 0, 0, 1);
        step(1, 8'h3B, 0, 1, 0);
        chk("ovf_push_pop", overflow, 0);
        status("t5b");
        idle(DEPTH + 1, 1);

        step(1, 8'h00, 0, 1, 0);
        step(1, 8'hFF, 0, 1, 0);
        step(1, 8'h00, 0, 1, 1);
        chk("clr_wins", err_cnt, 0);
        step(1, 8'hE0, 0, 1, 0);
        chk("pre_rst_busy", busy, 1);
        step(1, 8'h2A, 0, 0, 0);
        step(1, 8'hE0, 0, 0, 0);
        do_reset();

        for (int i = 0; i < 260; i++) step(1, 8'h00, 0, 1, 0);
        chk("sat", err_cnt, 255);
        step(1, 8'hFF, 0, 1, 0);
        chk("sat_hold", err_cnt, 255);
        do_reset();

        for (int i = 0; i < 4000; i++) begin
            int r = $urandom_range(0, 9);
            logic [7:0] d = 8'($urandom);
            if (r < 2) d = 8'hE0;
            else if (r < 4) d = 8'hF0;
            else if (r == 4) d = ($urandom_range(0, 1) != 0) ? 8'h00 : 8'hFF;
            step($urandom_range(0, 1) != 0, d, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 60) == 0);
            status("rnd");
        end

        idle(DEPTH + 2, 1);
        @(negedge clk);
        chk("drain", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
